// File: rtl/axis_packet_arbiter.sv
// Packet-level round-robin arbiter: NUM_PORTS AXI-Stream inputs share one output stream.
// A grant is held from the first beat of a packet to its tlast, so beats from different ports never interleave.
module axis_packet_arbiter #(
  parameter int NUM_PORTS     = 4,
  parameter int BITS_PER_BEAT = 512,
  parameter int PORT_ID_WIDTH = $clog2(NUM_PORTS)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_PORTS-1:0]                 port_enable,
  input  logic [NUM_PORTS-1:0]                 tvalid_in,
  input  logic [NUM_PORTS*BITS_PER_BEAT-1:0]   tdata_in,
  input  logic [NUM_PORTS-1:0]                 tlast_in,
  input  logic [NUM_PORTS*BITS_PER_BEAT/8-1:0] tkeep_in,
  output logic [NUM_PORTS-1:0]                 tready_out,
  output logic                                 tvalid_out,
  output logic [BITS_PER_BEAT-1:0]             tdata_out,
  output logic                                 tlast_out,
  output logic [BITS_PER_BEAT/8-1:0]           tkeep_out,
  output logic [PORT_ID_WIDTH-1:0]             tuser_port_out,
  input  logic                                 tready_in,
  output logic                                 busy,
  output logic [31:0]                          packet_count
);

  localparam int KEEP_WIDTH = BITS_PER_BEAT / 8;

  typedef enum logic {IDLE, FORWARD} state_t;

  state_t                   state_q, state_d;
  logic [PORT_ID_WIDTH-1:0] grant_q, grant_d;
  logic [PORT_ID_WIDTH-1:0] last_grant_q, last_grant_d;
  logic [31:0]              packet_count_q, packet_count_d;

  logic [NUM_PORTS-1:0]     req;
  logic [PORT_ID_WIDTH-1:0] rr_pick;
  logic                     rr_found;
  logic                     forwarding;
  logic                     last_transfer;

  logic [BITS_PER_BEAT-1:0] data_slice [NUM_PORTS];
  logic [KEEP_WIDTH-1:0]    keep_slice [NUM_PORTS];

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_slice
      assign data_slice[gi] = tdata_in[gi*BITS_PER_BEAT +: BITS_PER_BEAT];
      assign keep_slice[gi] = tkeep_in[gi*KEEP_WIDTH +: KEEP_WIDTH];
    end
  endgenerate

  assign req = tvalid_in & port_enable;

  // Search starts just after the previous winner, so that winner has lowest priority.
  always_comb begin
    logic [PORT_ID_WIDTH:0] idx;
    rr_pick  = '0;
    rr_found = 1'b0;
    idx      = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = {1'b0, last_grant_q} + (PORT_ID_WIDTH+1)'(i);
      if (idx >= (PORT_ID_WIDTH+1)'(NUM_PORTS)) begin
        idx = idx - (PORT_ID_WIDTH+1)'(NUM_PORTS);
      end
      if (!rr_found && req[idx[PORT_ID_WIDTH-1:0]]) begin
        rr_found = 1'b1;
        rr_pick  = idx[PORT_ID_WIDTH-1:0];
      end
    end
  end

  assign forwarding    = (state_q == FORWARD);
  assign last_transfer = forwarding && tvalid_in[grant_q] && tready_in && tlast_in[grant_q];

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    packet_count_d = packet_count_q;
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          grant_d = rr_pick;
          state_d = FORWARD;
        end
      end
      FORWARD: begin
        if (last_transfer) begin
          last_grant_d   = grant_q;
          packet_count_d = packet_count_q + 32'd1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      last_grant_q   <= PORT_ID_WIDTH'(NUM_PORTS - 1);
      packet_count_q <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      packet_count_q <= packet_count_d;
    end
  end

  // Pure pass-through of the granted port while forwarding; data lanes are don't-care in IDLE.
  always_comb begin
    tready_out = '0;
    if (forwarding) begin
      tready_out[grant_q] = tready_in;
    end
  end

  assign tvalid_out     = forwarding && tvalid_in[grant_q];
  assign tlast_out      = forwarding && tlast_in[grant_q];
  assign tdata_out      = data_slice[grant_q];
  assign tkeep_out      = keep_slice[grant_q];
  assign tuser_port_out = grant_q;
  assign busy           = forwarding;
  assign packet_count   = packet_count_q;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter: each task drives one scenario and checks outputs inline.
// Inputs change 2 time units after a rising edge; outputs are checked 1 unit later.
module tb_axis_packet_arbiter;
  localparam int N = 4;
  localparam int W = 512;
  localparam int K = W / 8;

  logic             clock = 1'b0;
  logic             reset;
  logic [N-1:0]     port_enable;
  logic [N-1:0]     tvalid_in;
  logic [N*W-1:0]   tdata_in;
  logic [N-1:0]     tlast_in;
  logic [N*K-1:0]   tkeep_in;
  logic [N-1:0]     tready_out;
  logic             tvalid_out;
  logic [W-1:0]     tdata_out;
  logic             tlast_out;
  logic [K-1:0]     tkeep_out;
  logic [1:0]       tuser_port_out;
  logic             tready_in;
  logic             busy;
  logic [31:0]      packet_count;

  int total = 0;
  int bad   = 0;

  axis_packet_arbiter #(.NUM_PORTS(N), .BITS_PER_BEAT(W)) dut (
    .clock(clock), .reset(reset), .port_enable(port_enable),
    .tvalid_in(tvalid_in), .tdata_in(tdata_in), .tlast_in(tlast_in), .tkeep_in(tkeep_in),
    .tready_out(tready_out), .tvalid_out(tvalid_out), .tdata_out(tdata_out),
    .tlast_out(tlast_out), .tkeep_out(tkeep_out), .tuser_port_out(tuser_port_out),
    .tready_in(tready_in), .busy(busy), .packet_count(packet_count)
  );

  always #5 clock = ~clock;

  task automatic step;
    @(posedge clock);
    #2;
  endtask

  task automatic set_beat(input int p, input logic v, input logic l, input logic [31:0] tag);
    tvalid_in[p]       = v;
    tlast_in[p]        = l;
    tdata_in[p*W +: W] = {16{tag}};
    tkeep_in[p*K +: K] = {8{tag[7:0]}};
  endtask

  function automatic logic [W-1:0] exp_data(input logic [31:0] tag);
    return {16{tag}};
  endfunction

  task automatic do_reset;
    reset       = 1'b1;
    port_enable = 4'hF;
    tvalid_in   = '0;
    tlast_in    = '0;
    tdata_in    = '0;
    tkeep_in    = '0;
    tready_in   = 1'b1;
    step;
    step;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    #1;
    total++;
    if (busy !== 1'b0 || tready_out !== 4'b0000 || tvalid_out !== 1'b0 || tlast_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs busy=%b tready=%b tvalid=%b tlast=%b want 0 0000 0 0",
               busy, tready_out, tvalid_out, tlast_out);
    end
    total++;
    if (packet_count !== 32'd0 || tuser_port_out !== 2'd0) begin
      bad++;
      $display("FAIL reset_state count=%0d grant=%0d want 0 0", packet_count, tuser_port_out);
    end
    $display("test_reset done");
  endtask

  task automatic test_single_port;
    do_reset;
    set_beat(2, 1'b1, 1'b0, 32'hA0);
    #1;
    total++;
    if (tvalid_out !== 1'b0 || tready_out !== 4'b0000) begin
      bad++;
      $display("FAIL sp_arb_cycle tvalid=%b tready=%b want 0 0000", tvalid_out, tready_out);
    end
    step;
    total++;
    if (tuser_port_out !== 2'd2 || tvalid_out !== 1'b1 || tready_out !== 4'b0100 ||
        busy !== 1'b1 || tlast_out !== 1'b0 || tdata_out !== exp_data(32'hA0)) begin
      bad++;
      $display("FAIL sp_beat0 grant=%0d tvalid=%b tready=%b busy=%b tlast=%b want 2 1 0100 1 0",
               tuser_port_out, tvalid_out, tready_out, busy, tlast_out);
    end
    step;
    set_beat(2, 1'b1, 1'b0, 32'hA1);
    #1;
    total++;
    if (tdata_out !== exp_data(32'hA1) || tvalid_out !== 1'b1) begin
      bad++;
      $display("FAIL sp_beat1 data=%0h tvalid=%b want %0h 1", tdata_out[31:0], tvalid_out, 32'hA1);
    end
    step;
    set_beat(2, 1'b1, 1'b1, 32'hA2);
    #1;
    total++;
    if (tlast_out !== 1'b1 || tkeep_out !== {8{8'hA2}} || tuser_port_out !== 2'd2) begin
      bad++;
      $display("FAIL sp_beat2 tlast=%b keep=%0h grant=%0d want 1 a2.. 2",
               tlast_out, tkeep_out[7:0], tuser_port_out);
    end
    step;
    set_beat(2, 1'b0, 1'b0, 32'h0);
    #1;
    total++;
    if (busy !== 1'b0 || tvalid_out !== 1'b0 || packet_count !== 32'd1) begin
      bad++;
      $display("FAIL sp_done busy=%b tvalid=%b count=%0d want 0 0 1", busy, tvalid_out, packet_count);
    end
    $display("test_single_port: port 2 3-beat packet, count=%0d", packet_count);
  endtask

  task automatic test_round_robin;
    do_reset;
    for (int p = 0; p < N; p++) set_beat(p, 1'b1, 1'b1, 32'h10 + p);
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if (tvalid_out !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL rr_idle_%0d tvalid=%b busy=%b want 0 0", k, tvalid_out, busy);
      end
      step;
      total++;
      if (tuser_port_out !== 2'(k % 4) || tvalid_out !== 1'b1 || tlast_out !== 1'b1 ||
          tready_out !== 4'(1 << (k % 4)) || tdata_out !== exp_data(32'h10 + (k % 4))) begin
        bad++;
        $display("FAIL rr_grant_%0d grant=%0d tready=%b tvalid=%b want %0d %b 1",
                 k, tuser_port_out, tready_out, tvalid_out, k % 4, 4'(1 << (k % 4)));
      end
      $display("rr packet %0d from port %0d", k, tuser_port_out);
      step;
    end
    tvalid_in = '0;
    #1;
    total++;
    if (packet_count !== 32'd5) begin
      bad++;
      $display("FAIL rr_count got=%0d want 5", packet_count);
    end
  endtask

  task automatic test_stall;
    do_reset;
    set_beat(1, 1'b1, 1'b0, 32'hB0);
    step;
    total++;
    if (tuser_port_out !== 2'd1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL st_grant grant=%0d busy=%b want 1 1", tuser_port_out, busy);
    end
    step;
    set_beat(1, 1'b1, 1'b0, 32'hB1);
    step;
    // granted port goes quiet mid-packet while port 0 requests: grant must hold
    set_beat(1, 1'b0, 1'b0, 32'hB2);
    set_beat(0, 1'b1, 1'b1, 32'hC0);
    for (int c = 0; c < 2; c++) begin
      #1;
      total++;
      if (tuser_port_out !== 2'd1 || busy !== 1'b1 || tvalid_out !== 1'b0 || tready_out !== 4'b0010) begin
        bad++;
        $display("FAIL st_gap_%0d grant=%0d busy=%b tvalid=%b tready=%b want 1 1 0 0010",
                 c, tuser_port_out, busy, tvalid_out, tready_out);
      end
      step;
    end
    set_beat(1, 1'b1, 1'b0, 32'hB2);
    tready_in   = 1'b0;
    port_enable = 4'b1101;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (tready_out !== 4'b0000 || tvalid_out !== 1'b1 || tuser_port_out !== 2'd1 ||
          tdata_out !== exp_data(32'hB2)) begin
        bad++;
        $display("FAIL st_stall_%0d tready=%b tvalid=%b grant=%0d want 0000 1 1",
                 c, tready_out, tvalid_out, tuser_port_out);
      end
      step;
    end
    tready_in = 1'b1;
    #1;
    total++;
    if (tready_out !== 4'b0010) begin
      bad++;
      $display("FAIL st_resume tready=%b want 0010", tready_out);
    end
    step;
    set_beat(1, 1'b1, 1'b1, 32'hB3);
    #1;
    total++;
    if (tlast_out !== 1'b1 || tuser_port_out !== 2'd1) begin
      bad++;
      $display("FAIL st_last tlast=%b grant=%0d want 1 1", tlast_out, tuser_port_out);
    end
    step;
    set_beat(1, 1'b0, 1'b0, 32'h0);
    #1;
    total++;
    if (busy !== 1'b0 || packet_count !== 32'd1) begin
      bad++;
      $display("FAIL st_end busy=%b count=%0d want 0 1", busy, packet_count);
    end
    step;
    total++;
    if (tuser_port_out !== 2'd0 || busy !== 1'b1 || tready_out !== 4'b0001) begin
      bad++;
      $display("FAIL st_next grant=%0d busy=%b tready=%b want 0 1 0001", tuser_port_out, busy, tready_out);
    end
    step;
    set_beat(0, 1'b0, 1'b0, 32'h0);
    port_enable = 4'hF;
    #1;
    total++;
    if (packet_count !== 32'd2) begin
      bad++;
      $display("FAIL st_count got=%0d want 2", packet_count);
    end
    $display("test_stall: port 1 packet held through stall, then port 0");
  endtask

  task automatic test_mask;
    do_reset;
    port_enable = 4'b1011;
    set_beat(2, 1'b1, 1'b1, 32'h22);
    set_beat(3, 1'b1, 1'b1, 32'h33);
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (tready_out[2] !== 1'b0 || tvalid_out !== 1'b0) begin
        bad++;
        $display("FAIL mask_idle_%0d tready=%b tvalid=%b want x0xx 0", k, tready_out, tvalid_out);
      end
      step;
      total++;
      if (tuser_port_out !== 2'd3 || tready_out !== 4'b1000 || tdata_out !== exp_data(32'h33)) begin
        bad++;
        $display("FAIL mask_grant_%0d grant=%0d tready=%b want 3 1000", k, tuser_port_out, tready_out);
      end
      $display("mask packet %0d from port %0d", k, tuser_port_out);
      step;
    end
    tvalid_in = '0;
    #1;
    total++;
    if (packet_count !== 32'd3) begin
      bad++;
      $display("FAIL mask_count got=%0d want 3", packet_count);
    end
  endtask

  task automatic test_wrap;
    do_reset;
    force dut.packet_count_q = 32'hFFFF_FFFF;
    step;
    release dut.packet_count_q;
    #1;
    total++;
    if (packet_count !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL wrap_preload got=%0h want ffffffff", packet_count);
    end
    set_beat(0, 1'b1, 1'b1, 32'h5A);
    step;
    step;
    set_beat(0, 1'b0, 1'b0, 32'h0);
    #1;
    total++;
    if (packet_count !== 32'd0) begin
      bad++;
      $display("FAIL wrap_count got=%0h want 0", packet_count);
    end
    $display("test_wrap: count=%0h", packet_count);
  endtask

  task automatic test_reset_mid_packet;
    do_reset;
    set_beat(3, 1'b1, 1'b0, 32'h30);
    step;
    step;
    step;
    total++;
    if (tuser_port_out !== 2'd3 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rm_grant grant=%0d busy=%b want 3 1", tuser_port_out, busy);
    end
    reset = 1'b1;
    set_beat(0, 1'b1, 1'b1, 32'h40);
    step;
    reset = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || tready_out !== 4'b0000 || tvalid_out !== 1'b0 || packet_count !== 32'd0) begin
      bad++;
      $display("FAIL rm_after_reset busy=%b tready=%b tvalid=%b count=%0d want 0 0000 0 0",
               busy, tready_out, tvalid_out, packet_count);
    end
    step;
    total++;
    if (tuser_port_out !== 2'd0 || busy !== 1'b1 || tready_out !== 4'b0001) begin
      bad++;
      $display("FAIL rm_regrant grant=%0d busy=%b tready=%b want 0 1 0001", tuser_port_out, busy, tready_out);
    end
    step;
    tvalid_in = '0;
    $display("test_reset_mid_packet done");
  endtask

  initial begin
    test_reset;
    test_single_port;
    test_round_robin;
    test_stall;
    test_mask;
    test_wrap;
    test_reset_mid_packet;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired before test sequence finished");
    $fatal(1, "timeout");
  end
endmodule
